// File: rtl/scan_sequencer_if.sv
// Scan sequencer bus: enable/mask in, channel select and strobes out.
// master drives en/mask; slave (the sequencer) drives sel/valid/tick/wrap.
interface scan_sequencer_if;
  logic       en;
  logic [3:0] mask;
  logic [1:0] sel;
  logic       valid;
  logic       tick;
  logic       wrap;

  modport master (
    output en, mask,
    input  sel, valid, tick, wrap
  );

  modport slave (
    input  en, mask,
    output sel, valid, tick, wrap
  );
endinterface

// File: rtl/scan_sequencer.sv
// Round-robin scanner over 4 channels, PRESCALE cycles per enabled slot.
// Ports: clk, rst (sync, active-high), bus (slave: en/mask in, sel/valid/tick/wrap out).
module scan_sequencer #(
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst,
  scan_sequencer_if.slave   bus
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    sel_q;
  logic          valid_q;
  logic          tick_q;
  logic          wrap_q;

  logic [1:0]    nxt;
  logic [1:0]    idx;
  logic          hit;
  logic          scan;
  logic          adv;

  assign scan = bus.en && (bus.mask != 4'b0000);
  // A masked current channel forces an immediate step.
  assign adv  = (cnt == LAST) || !bus.mask[sel_q];

  // First enabled channel after sel in circular order; falls back to sel.
  always_comb begin
    nxt = sel_q;
    idx = sel_q;
    hit = 1'b0;
    for (int i = 1; i < 5; i++) begin
      idx = sel_q + 2'(i);
      if (!hit && bus.mask[idx]) begin
        nxt = idx;
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (!scan) begin
      cnt     <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (adv) begin
      cnt     <= '0;
      sel_q   <= nxt;
      valid_q <= 1'b1;
      tick_q  <= 1'b1;
      wrap_q  <= (nxt <= sel_q);
    end else begin
      cnt     <= cnt + CW'(1);
      valid_q <= 1'b1;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer with PRESCALE=4.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_scan_sequencer;

  typedef struct {
    string      nm;
    logic [1:0] sel;
    logic       valid;
    logic       tick;
    logic       wrap;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q[$];

  scan_sequencer_if bus();

  scan_sequencer #(.PRESCALE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (bus.sel !== x.sel || bus.valid !== x.valid ||
          bus.tick !== x.tick || bus.wrap !== x.wrap) begin
        errors++;
        $display("FAIL %s t=%0t: got sel=%0d v=%b t=%b w=%b, want sel=%0d v=%b t=%b w=%b",
                 x.nm, $time, bus.sel, bus.valid, bus.tick, bus.wrap,
                 x.sel, x.valid, x.tick, x.wrap);
      end
    end
  end

  task automatic cyc(input string nm, input logic r, input logic e,
                     input logic [3:0] m, input logic [1:0] s,
                     input logic v, input logic t, input logic w);
    exp_t x;
    rst      = r;
    bus.en   = e;
    bus.mask = m;
    x.nm     = nm;
    x.sel    = s;
    x.valid  = v;
    x.tick   = t;
    x.wrap   = w;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Full 4-cycle slot from cnt=0: three holds then a step.
  task automatic dwell(input string nm, input logic [3:0] m,
                       input logic [1:0] hold, input logic [1:0] nsel,
                       input logic nw);
    repeat (3) cyc(nm, 1'b0, 1'b1, m, hold, 1'b1, 1'b0, 1'b0);
    cyc(nm, 1'b0, 1'b1, m, nsel, 1'b1, 1'b1, nw);
  endtask

  task automatic do_reset(input string nm);
    repeat (2) cyc(nm, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.mask = 4'b0000;
    checks   = 0;
    errors   = 0;

    do_reset("reset");
    dwell("full0", 4'b1111, 2'd0, 2'd1, 1'b0);
    dwell("full1", 4'b1111, 2'd1, 2'd2, 1'b0);
    dwell("full2", 4'b1111, 2'd2, 2'd3, 1'b0);
    dwell("full3", 4'b1111, 2'd3, 2'd0, 1'b1);
    dwell("full4", 4'b1111, 2'd0, 2'd1, 1'b0);

    do_reset("reset2");
    cyc("sparse_force", 1'b0, 1'b1, 4'b1010, 2'd1, 1'b1, 1'b1, 1'b0);
    dwell("sparse_a", 4'b1010, 2'd1, 2'd3, 1'b0);
    dwell("sparse_b", 4'b1010, 2'd3, 2'd1, 1'b1);
    dwell("sparse_c", 4'b1010, 2'd1, 2'd3, 1'b0);
    dwell("sparse_d", 4'b1010, 2'd3, 2'd1, 1'b1);

    do_reset("reset3");
    cyc("single_force", 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    dwell("single_a", 4'b0100, 2'd2, 2'd2, 1'b1);
    dwell("single_b", 4'b0100, 2'd2, 2'd2, 1'b1);

    do_reset("reset4");
    dwell("drop_pre", 4'b1111, 2'd0, 2'd1, 1'b0);
    cyc("drop_cnt1", 1'b0, 1'b1, 4'b1111, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc("drop_force", 1'b0, 1'b1, 4'b1101, 2'd2, 1'b1, 1'b1, 1'b0);
    dwell("drop_ch2", 4'b1101, 2'd2, 2'd3, 1'b0);
    dwell("drop_ch3", 4'b1101, 2'd3, 2'd0, 1'b1);
    dwell("drop_ch0", 4'b1101, 2'd0, 2'd2, 1'b0);

    repeat (2) cyc("gap_pre", 1'b0, 1'b1, 4'b1101, 2'd2, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc("gap_off", 1'b0, 1'b0, 4'b1101, 2'd2, 1'b0, 1'b0, 1'b0);
    dwell("gap_resume", 4'b1101, 2'd2, 2'd3, 1'b0);
    repeat (3) cyc("zero_mask", 1'b0, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
    dwell("zero_resume", 4'b1111, 2'd3, 2'd0, 1'b1);

    dwell("rst_a", 4'b1111, 2'd0, 2'd1, 1'b0);
    dwell("rst_b", 4'b1111, 2'd1, 2'd2, 1'b0);
    dwell("rst_c", 4'b1111, 2'd2, 2'd3, 1'b0);
    repeat (3) cyc("rst_pre", 1'b0, 1'b1, 4'b1111, 2'd3, 1'b1, 1'b0, 1'b0);
    cyc("rst_mid", 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0);
    dwell("rst_after", 4'b1111, 2'd0, 2'd1, 1'b0);

    bus.en = 1'b0;
    rst    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
